fp_result_buf: RTL and testbench
================================

// Module: fp_result_buf
// PURPOSE
//  Commit buffer directly downstream of fp_rnd. Captures each rounded result
//  (result + status_t flags) with an issue tag in a small FIFO under valid/ready
//  handshake. Accumulates sticky exception flags (fflags) at commit time.
//  Decouples multi-cycle units (fp_div, fp_sqrt) from a stalling writeback port.
// PARAMETERS
//  FP_FORMAT  FP32  fp_format_e; sets FP_WIDTH = fp_width(FP_FORMAT)
//  DEPTH      4     FIFO entries; power of two, >= 2
//  TAG_WIDTH  5     width of the destination tag carried with each result
// PORTS
//  clk_i         in   1                  clock, rising edge
//  reset_i       in   1                  synchronous reset, active-low
//  in_valid_i    in   1                  rounded result presented by fp_rnd side
//  in_ready_o    out  1                  buffer can accept (not full)
//  result_i      in   FP_WIDTH           rnd_result.result
//  flags_i       in   5 (status_t)       rnd_result.flags {NV,DZ,OF,UF,NX}
//  tag_i         in   TAG_WIDTH          destination tag
//  out_valid_o   out  1                  head entry valid
//  out_ready_i   in   1                  consumer accepts head entry
//  result_o      out  FP_WIDTH           head result
//  flags_o       out  5 (status_t)       head flags
//  tag_o         out  TAG_WIDTH          head tag
//  fflags_o      out  5 (status_t)       sticky OR of committed flags
//  fflags_clr_i  in   1                  clear sticky flags
//  count_o       out  $clog2(DEPTH+1)    occupied entries
// BEHAVIOUR
//  - Reset (reset_i=0 at posedge): wr/rd ptr=0, count_o=0, out_valid_o=0,
//    fflags_o=0; in_ready_o=0 while reset_i=0, 1 on the first cycle after release.
//  - result_o/flags_o/tag_o forced to 0 whenever out_valid_o=0.
//  - Enqueue: in_valid_i & in_ready_o at posedge; write at wr_ptr, wr_ptr+1 mod DEPTH.
//  - Dequeue: out_valid_o & out_ready_i at posedge; rd_ptr+1 mod DEPTH.
//  - in_ready_o = (count_o != DEPTH); out_valid_o = (count_o != 0); both depend
//    only on registered state: no combinational path from in_* to out_* or back.
//  - Latency: accepted entry visible on out_* the next cycle; no empty bypass.
//  - Simultaneous enq+deq (not full, not empty): count unchanged, both pointers advance.
//  - Full: in_ready_o=0; a dequeue that cycle frees a slot, in_ready_o=1 next cycle.
//  - Empty: out_ready_i ignored; count never underflows.
//  - Inputs with in_valid_i=0 or in_ready_o=0 are ignored (no state change).
//  - Order strictly FIFO; entries never dropped or duplicated.
//  - Sticky: on dequeue, fflags_o <= fflags_o | flags_o(head). fflags_clr_i
//    alone -> 0. clr + dequeue in the same cycle -> fflags_o <= flags_o(head)
//    (clear first, then OR).
//  - Reset mid-operation discards all entries and sticky flags at that edge.
// CONFIGURATION
//  FP_RESULT_BUF_CANON_NAN_EN defined: any result_i with exp all-ones and mantissa
//    != 0 is stored as the canonical quiet NaN (FP32: 32'h7FC0_0000, sign 0).
//    flags_i are stored unchanged.
//  Not defined: result_i is stored bit-exact (NaN payload and sign preserved).
// TESTING
//  1 Reset: hold reset_i=0 for 3 cycles -> out_valid_o=0, count_o=0,
//    fflags_o=0, in_ready_o=0; release -> in_ready_o=1.
//  2 Single pass: enq 32'h3F800000, flags 0, tag 3 -> next cycle out_valid_o=1,
//    result_o=3F800000, tag_o=3; out_ready_i=1 -> count_o=0.
//  3 Fill/full: out_ready_i=0, push 5 entries (tags 0..4) -> 4 accepted,
//    in_ready_o=0, count_o=4; drain -> tags 0,1,2,3 in order; tag 4 was never accepted.
//  4 Full + simultaneous: full, out_ready_i=1 and in_valid_i=1 -> one dequeue,
//    no enqueue that cycle; in_ready_o=1 next cycle; count_o=3.
//  5 Sticky: commit flags 00001 (NX), then 00100 (OF) -> fflags_o=00101;
//    assert fflags_clr_i with a dequeue of 10000 -> fflags_o=10000.
//  6 NaN: enq 32'hFFC0_1234 -> result_o=7FC00000 with FP_RESULT_BUF_CANON_NAN_EN
//    defined, FFC01234 without it.

Source files
------------

// File: rtl/fp_result_buf.sv
// Commit FIFO behind the rounding stage: buffers rounded results with their tags
// and accumulates sticky exception flags on commit. Option: FP_RESULT_BUF_CANON_NAN_EN.
package fp_result_buf_pkg;
    typedef enum logic [1:0] {FP16, FP32, FP64} fp_format_e;

    function automatic int fp_width(fp_format_e fmt);
        case (fmt)
            FP16:    return 16;
            FP64:    return 64;
            default: return 32;
        endcase
    endfunction

    function automatic int fp_exp_bits(fp_format_e fmt);
        case (fmt)
            FP16:    return 5;
            FP64:    return 11;
            default: return 8;
        endcase
    endfunction
endpackage

module fp_result_buf
    import fp_result_buf_pkg::*;
#(
    parameter fp_format_e FP_FORMAT = FP32,
    parameter int DEPTH = 4,
    parameter int TAG_WIDTH = 5,
    localparam int FP_WIDTH = fp_width(FP_FORMAT),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [FP_WIDTH-1:0]  result_i,
    input  logic [4:0]           flags_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [FP_WIDTH-1:0]  result_o,
    output logic [4:0]           flags_o,
    output logic [TAG_WIDTH-1:0] tag_o,
    output logic [4:0]           fflags_o,
    input  logic                 fflags_clr_i,
    output logic [CW-1:0]        count_o
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [FP_WIDTH-1:0]  result;
        logic [4:0]           flags;
        logic [TAG_WIDTH-1:0] tag;
    } entry_t;

    entry_t              mem [DEPTH];
    entry_t              head;
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;
    logic [4:0]          fflags;
    logic                enq, deq;
    logic [FP_WIDTH-1:0] wr_result;

`ifdef FP_RESULT_BUF_CANON_NAN_EN
    localparam int EW = fp_exp_bits(FP_FORMAT);
    localparam int MW = FP_WIDTH - 1 - EW;
    localparam logic [FP_WIDTH-1:0] CANON_NAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

    // Any NaN (quiet or signalling, any sign/payload) collapses to the canonical qNaN.
    always_comb begin
        wr_result = result_i;
        if (&result_i[FP_WIDTH-2 -: EW] && |result_i[MW-1:0])
            wr_result = CANON_NAN;
    end
`else
    assign wr_result = result_i;
`endif

    // Ready is held low while reset is asserted, otherwise only registered state.
    assign in_ready_o  = reset_i && (count != CW'(DEPTH));
    assign out_valid_o = (count != '0);
    assign enq         = in_valid_i && in_ready_o;
    assign deq         = out_valid_o && out_ready_i;

    assign head     = mem[rd_ptr];
    assign result_o = out_valid_o ? head.result : '0;
    assign flags_o  = out_valid_o ? head.flags  : '0;
    assign tag_o    = out_valid_o ? head.tag    : '0;
    assign fflags_o = fflags;
    assign count_o  = count;

    always_ff @(posedge clk_i) begin
        if (enq)
            mem[wr_ptr] <= '{result: wr_result, flags: flags_i, tag: tag_i};
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            fflags <= '0;
        end else begin
            if (enq)
                wr_ptr <= wr_ptr + PW'(1);
            if (deq)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(enq) - CW'(deq);
            // Clear takes effect before the committing entry's flags are merged.
            fflags <= (fflags_clr_i ? 5'b0 : fflags) | (deq ? head.flags : 5'b0);
        end
    end
endmodule

// File: tb/tb_fp_result_buf.sv
// Randomized + directed bench for fp_result_buf against a queue-based reference model.
module tb_fp_result_buf;
    localparam int DEPTH = 4;

    logic        clk = 0;
    logic        reset_i = 0;
    logic        in_valid_i = 0;
    logic        in_ready_o;
    logic [31:0] result_i = '0;
    logic [4:0]  flags_i = '0;
    logic [4:0]  tag_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 0;
    logic [31:0] result_o;
    logic [4:0]  flags_o;
    logic [4:0]  tag_o;
    logic [4:0]  fflags_o;
    logic        fflags_clr_i = 0;
    logic [2:0]  count_o;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] r;
        logic [4:0]  f;
        logic [4:0]  t;
    } ent_t;

    ent_t       mq[$];
    logic [4:0] mff = '0;

    fp_result_buf dut (
        .clk_i(clk), .reset_i(reset_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .result_i(result_i), .flags_i(flags_i), .tag_i(tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o), .flags_o(flags_o), .tag_o(tag_o),
        .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i), .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] stored(input logic [31:0] r);
`ifdef FP_RESULT_BUF_CANON_NAN_EN
        if (r[30:23] == 8'hFF && r[22:0] != 0) return 32'h7FC0_0000;
`endif
        return r;
    endfunction

    task automatic check_outs();
        int n = mq.size();
        chk("count", 64'(count_o), 64'(n));
        chk("out_valid", 64'(out_valid_o), 64'(n != 0));
        chk("in_ready", 64'(in_ready_o), 64'(reset_i && n < DEPTH));
        chk("fflags", 64'(fflags_o), 64'(mff));
        chk("result", 64'(result_o), n != 0 ? 64'(mq[0].r) : 64'd0);
        chk("flags", 64'(flags_o), n != 0 ? 64'(mq[0].f) : 64'd0);
        chk("tag", 64'(tag_o), n != 0 ? 64'(mq[0].t) : 64'd0);
    endtask

    // Called at a negedge: check, drive, clock, advance model, return at next negedge.
    task automatic step(input logic iv, input logic [31:0] r, input logic [4:0] f,
                        input logic [4:0] t, input logic ordy, input logic clr, input logic rst);
        bit   can_take;
        ent_t e;
        check_outs();
        reset_i = rst; in_valid_i = iv; result_i = r; flags_i = f; tag_i = t;
        out_ready_i = ordy; fflags_clr_i = clr;
        @(posedge clk);
        if (!rst) begin
            mq.delete();
            mff = '0;
        end else begin
            can_take = mq.size() < DEPTH;
            if (clr) mff = '0;
            if (ordy && mq.size() > 0) begin
                e = mq.pop_front();
                mff |= e.f;
            end
            if (iv && can_take) mq.push_back('{stored(r), f, t});
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'h0, 5'h0, 5'h0, ordy, 1'b0, 1'b1);
    endtask

    task automatic push(input logic [31:0] r, input logic [4:0] f, input logic [4:0] t, input logic ordy);
        step(1'b1, r, f, t, ordy, 1'b0, 1'b1);
    endtask

    initial begin
        @(negedge clk);
        // Reset held three cycles
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 5'h0, 5'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_fflags", 64'(fflags_o), 64'd0);
        chk("rst_in_ready", 64'(in_ready_o), 64'd0);
        idle(1'b0);
        chk("rel_in_ready", 64'(in_ready_o), 64'd1);

        // Single pass
        push(32'h3F80_0000, 5'h0, 5'd3, 1'b0);
        chk("sp_valid", 64'(out_valid_o), 64'd1);
        chk("sp_result", 64'(result_o), 64'h3F80_0000);
        chk("sp_tag", 64'(tag_o), 64'd3);
        idle(1'b1);
        chk("sp_count", 64'(count_o), 64'd0);

        // Fill past full: tag 4 must be refused
        for (int i = 0; i < 5; i++) push(32'h4000_0000 + 32'(i), 5'h0, 5'(i), 1'b0);
        chk("full_ready", 64'(in_ready_o), 64'd0);
        chk("full_count", 64'(count_o), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("drain_tag", 64'(tag_o), 64'(i));
            idle(1'b1);
        end
        chk("drain_empty", 64'(count_o), 64'd0);
        // Dequeue on empty must not underflow
        idle(1'b1);
        chk("empty_deq", 64'(count_o), 64'd0);

        // Full with simultaneous push/pop: only the pop happens
        for (int i = 0; i < 4; i++) push(32'h1, 5'h0, 5'(10 + i), 1'b0);
        push(32'h2, 5'h0, 5'd20, 1'b1);
        chk("fs_count", 64'(count_o), 64'd3);
        chk("fs_ready", 64'(in_ready_o), 64'd1);
        chk("fs_head", 64'(tag_o), 64'd11);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Sticky accumulation and clear-then-OR
        step(1'b0, 32'h0, 5'h0, 5'h0, 1'b0, 1'b1, 1'b1);
        push(32'h5, 5'b00001, 5'd1, 1'b0);
        push(32'h6, 5'b00100, 5'd2, 1'b0);
        push(32'h7, 5'b10000, 5'd3, 1'b0);
        idle(1'b1);
        idle(1'b1);
        chk("sticky_or", 64'(fflags_o), 64'b00101);
        step(1'b0, 32'h0, 5'h0, 5'h0, 1'b1, 1'b1, 1'b1);
        chk("sticky_clr_deq", 64'(fflags_o), 64'b10000);

        // NaN handling
        push(32'hFFC0_1234, 5'h0, 5'd7, 1'b0);
`ifdef FP_RESULT_BUF_CANON_NAN_EN
        chk("nan_result", 64'(result_o), 64'h7FC0_0000);
`else
        chk("nan_result", 64'(result_o), 64'hFFC0_1234);
`endif
        idle(1'b1);

        // Reset mid-operation discards entries and sticky flags
        push(32'h9, 5'b01000, 5'd9, 1'b0);
        push(32'hA, 5'b00010, 5'd9, 1'b1);
        step(1'b0, 32'h0, 5'h0, 5'h0, 1'b0, 1'b0, 1'b0);
        chk("midrst_count", 64'(count_o), 64'd0);
        chk("midrst_fflags", 64'(fflags_o), 64'd0);
        idle(1'b0);

        // Random traffic with phases biased toward fill and drain
        for (int i = 0; i < 600; i++) begin
            logic [31:0] r;
            logic        ordy;
            case ($urandom_range(0, 4))
                0: r = {1'($urandom), 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
                1: r = {1'($urandom), 8'hFF, 23'h0};
                default: r = $urandom;
            endcase
            ordy = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 3) != 0, r, 5'($urandom), 5'($urandom), ordy,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 99) != 0);
        end
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
        check_outs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
